// File: rtl/div_pkg.sv
// Shared types and constants for the sequential shift-subtract divider.
package div_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_LOG2W = 4;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compare/subtract the aligned divisor, shift a
// quotient bit in and move the divisor one position right.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] dsh,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next,
  output logic [WIDTH-1:0] dsh_next
);

  logic [WIDTH:0] diff;
  logic           ge;

  // The extra top bit of diff is the borrow: clear means r >= dsh.
  always_comb begin
    diff     = {1'b0, r} - {1'b0, dsh};
    ge       = ~diff[WIDTH];
    r_next   = ge ? diff[WIDTH-1:0] : r;
    q_next   = (q << 1) | {{(WIDTH-1){1'b0}}, ge};
    dsh_next = dsh >> 1;
  end

endmodule

// File: rtl/seq_divider_16.sv
// Sequential unsigned divider that aligns the divisor using precomputed MSB
// positions, so it iterates only MSB_N-MSB_D+1 times.
module seq_divider_16
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int LOG2W = DIV_LOG2W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N16b,
  input  logic [WIDTH-1:0] D16b,
  input  logic [LOG2W-1:0] MSB_N,
  input  logic [LOG2W-1:0] MSB_D,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_t       state_reg;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] d_reg;
  logic [LOG2W-1:0] msb_n_reg;
  logic [LOG2W-1:0] msb_d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] dsh_reg;
  logic [LOG2W-1:0] cnt_reg;
  logic [LOG2W-1:0] shift;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] dsh_step;

  // Only meaningful once msb_n_reg >= msb_d_reg; the early exits cover the rest.
  assign shift = msb_n_reg - msb_d_reg;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r       (r_reg),
    .q       (q_reg),
    .dsh     (dsh_reg),
    .r_next  (r_step),
    .q_next  (q_step),
    .dsh_next(dsh_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      n_reg       <= '0;
      d_reg       <= '0;
      msb_n_reg   <= '0;
      msb_d_reg   <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      dsh_reg     <= '0;
      cnt_reg     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            n_reg       <= N16b;
            d_reg       <= D16b;
            msb_n_reg   <= MSB_N;
            msb_d_reg   <= MSB_D;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state_reg   <= LOAD;
          end
        end
        LOAD: begin
          if (d_reg == '0) begin
            div_by_zero <= 1'b1;
            quotient    <= DIV0_QUOTIENT;
            remainder   <= n_reg;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_reg   <= DONE;
          end else if (n_reg == '0 || msb_n_reg < msb_d_reg) begin
            quotient  <= '0;
            remainder <= n_reg;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            dsh_reg   <= d_reg << shift;
            r_reg     <= n_reg;
            q_reg     <= '0;
            cnt_reg   <= shift;
            state_reg <= ITER;
          end
        end
        ITER: begin
          r_reg   <= r_step;
          q_reg   <= q_step;
          dsh_reg <= dsh_step;
          // Results go straight from the final step to the outputs so they are
          // visible in the DONE cycle.
          if (cnt_reg == '0) begin
            quotient  <= q_step;
            remainder <= r_step;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - LOG2W'(1);
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_16.sv
// Directed bench for seq_divider_16: a transaction-level reference model checked
// every cycle, plus hand-computed literal results and latencies.
module tb_seq_divider_16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] n16b = '0;
  logic [15:0] d16b = '0;
  logic [3:0]  msb_n = '0;
  logic [3:0]  msb_d = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [15:0] quotient;
  logic [15:0] remainder;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  seq_divider_16 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .N16b       (n16b),
    .D16b       (d16b),
    .MSB_N      (msb_n),
    .MSB_D      (msb_d),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] msb_of(input logic [15:0] x);
    logic [3:0] m;
    m = 4'd0;
    for (int i = 0; i < 16; i++) if (x[i]) m = 4'(i);
    return m;
  endfunction

  // Reference results and latency (cycles from the start cycle to done).
  function automatic logic [15:0] f_q(input logic [15:0] n, d, input logic [3:0] mn, md);
    if (d == 16'd0) return 16'hFFFF;
    if (n == 16'd0 || mn < md) return 16'd0;
    return n / d;
  endfunction

  function automatic logic [15:0] f_r(input logic [15:0] n, d, input logic [3:0] mn, md);
    if (d == 16'd0 || n == 16'd0 || mn < md) return n;
    return n % d;
  endfunction

  function automatic int f_lat(input logic [15:0] n, d, input logic [3:0] mn, md);
    if (d == 16'd0 || n == 16'd0 || mn < md) return 2;
    return int'(mn) - int'(md) + 3;
  endfunction

  int          m_left = 0;
  bit          m_in_done = 1'b0;
  logic [15:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  bit          m_dz = 1'b0, p_dz = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left    <= 0;
      m_in_done <= 1'b0;
      m_q       <= '0;
      m_r       <= '0;
      m_dz      <= 1'b0;
    end else if (m_in_done) begin
      m_in_done <= 1'b0;
    end else if (m_left > 1) begin
      m_left <= m_left - 1;
    end else if (m_left == 1) begin
      m_left    <= 0;
      m_in_done <= 1'b1;
      m_q       <= p_q;
      m_r       <= p_r;
      m_dz      <= p_dz;
    end else if (start) begin
      m_left <= f_lat(n16b, d16b, msb_n, msb_d) - 1;
      p_q    <= f_q(n16b, d16b, msb_n, msb_d);
      p_r    <= f_r(n16b, d16b, msb_n, msb_d);
      p_dz   <= (d16b == 16'd0);
      m_dz   <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("mon_busy", 32'(busy), 32'(m_left > 0));
      chk("mon_done", 32'(done), 32'(m_in_done));
      chk("mon_dz", 32'(div_by_zero), 32'(m_dz));
      chk("mon_quotient", 32'(quotient), 32'(m_q));
      chk("mon_remainder", 32'(remainder), 32'(m_r));
    end
  end

  task automatic run_op(input string tag, input logic [15:0] n, d, eq, er,
                        input logic edz, input int elat);
    int  c;
    bit  got;
    c   = 0;
    got = 1'b0;
    @(negedge clk);
    n16b  = n;
    d16b  = d;
    msb_n = msb_of(n);
    msb_d = msb_of(d);
    start = 1'b1;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done) begin
        got = 1'b1;
        c   = i;
      end
    end
    chk({tag, "_latency"}, 32'(c), 32'(elat));
    chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
    chk({tag, "_remainder"}, 32'(remainder), 32'(er));
    chk({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
    $display("op %s: N=%0d D=%0d -> q=%0d r=%0d dz=%0b latency=%0d", tag, n, d, quotient, remainder, div_by_zero, c);
  endtask

  initial begin
    int c1, c2;
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    run_op("d100_7",   16'd100,   16'd7,      16'd14,     16'd2,      1'b0, 7);
    run_op("ffff_1",   16'hFFFF,  16'd1,      16'hFFFF,   16'd0,      1'b0, 18);
    run_op("n_lt_d",   16'd5,     16'd9,      16'd0,      16'd5,      1'b0, 2);
    run_op("d_zero",   16'd1234,  16'd0,      16'hFFFF,   16'd1234,   1'b1, 2);
    run_op("after_dz", 16'd1000,  16'd3,      16'd333,    16'd1,      1'b0, 11);
    run_op("n_zero",   16'd0,     16'd3,      16'd0,      16'd0,      1'b0, 2);
    run_op("equal",    16'd7,     16'd7,      16'd1,      16'd0,      1'b0, 3);
    run_op("same_msb", 16'd5,     16'd7,      16'd0,      16'd5,      1'b0, 3);
    run_op("top_bits", 16'hFFFF,  16'h8001,   16'd1,      16'h7FFE,   1'b0, 3);

    // Start held high across two operations.
    c1 = 0;
    c2 = 0;
    @(negedge clk);
    n16b  = 16'd100;
    d16b  = 16'd7;
    msb_n = msb_of(16'd100);
    msb_d = msb_of(16'd7);
    start = 1'b1;
    for (int i = 1; i <= 40 && c1 == 0; i++) begin
      @(negedge clk);
      if (done) c1 = i;
    end
    n16b  = 16'd50;
    d16b  = 16'd5;
    msb_n = msb_of(16'd50);
    msb_d = msb_of(16'd5);
    chk("b2b_first_latency", 32'(c1), 32'd7);
    chk("b2b_first_quotient", 32'(quotient), 32'd14);
    @(negedge clk);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_hold_quotient", 32'(quotient), 32'd14);
    chk("b2b_hold_remainder", 32'(remainder), 32'd2);
    @(negedge clk);
    chk("b2b_second_accept", 32'(busy), 32'd1);
    start = 1'b0;
    for (int j = 1; j <= 40 && c2 == 0; j++) begin
      @(negedge clk);
      if (done) c2 = j + 1;
    end
    chk("b2b_second_latency", 32'(c2), 32'd6);
    chk("b2b_second_quotient", 32'(quotient), 32'd10);
    chk("b2b_second_remainder", 32'(remainder), 32'd0);
    $display("op b2b: first latency=%0d second latency=%0d q=%0d r=%0d", c1, c2, quotient, remainder);

    // Reset partway through an operation.
    @(negedge clk);
    n16b  = 16'd100;
    d16b  = 16'd7;
    msb_n = msb_of(16'd100);
    msb_d = msb_of(16'd7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_quotient", 32'(quotient), 32'd0);
    chk("midrst_remainder", 32'(remainder), 32'd0);
    $display("op midrst: busy=%0b done=%0b q=%0d r=%0d", busy, done, quotient, remainder);
    @(posedge clk);
    #2 rst = 1'b0;
    run_op("post_rst", 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 6);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
